matrix_bus_sequencer: RTL and testbench

MATRIX_BUS_SEQUENCER -- requirements
Module: matrix_bus_sequencer

---
 rtl/matrix_bus_sequencer_if.sv | 33 +++
 rtl/matrix_bus_sequencer.sv | 77 +++++++
 tb/tb_matrix_bus_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_bus_sequencer_if.sv
// matrix_bus_sequencer_if: element stream, ALU databus/control and result stream of the matrix sequencer
interface matrix_bus_sequencer_if #(
  parameter int DATASIZE    = 16,
  parameter int MEMORY_SIZE = 256
);
  logic [DATASIZE-1:0]    in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   op_addsub;
  logic [MEMORY_SIZE-1:0] bus_wdata;
  logic [MEMORY_SIZE-1:0] bus_rdata;
  logic                   enable;
  logic                   select;
  logic                   readwrite;
  logic                   ab_select;
  logic                   addsub;
  logic                   done;
  logic [DATASIZE-1:0]    out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   timeout_err;
  modport master (
    input  in_data, in_valid, op_addsub, bus_rdata, done, out_ready,
    output in_ready, bus_wdata, enable, select, readwrite, ab_select, addsub,
           out_data, out_valid, busy, timeout_err
  );
  modport slave (
    output in_data, in_valid, op_addsub, bus_rdata, done, out_ready,
    input  in_ready, bus_wdata, enable, select, readwrite, ab_select, addsub,
           out_data, out_valid, busy, timeout_err
  );
endinterface

// File: rtl/matrix_bus_sequencer.sv
// matrix_bus_sequencer: packs two streamed matrices onto the ALU databus, waits for done, streams the result back
module matrix_bus_sequencer #(
  parameter int DATASIZE      = 16,
  parameter int REGISTER_SIZE = 4,
  parameter int MEMORY_SIZE   = 256,
  parameter int DONE_TIMEOUT  = 255
) (
  input logic                    clk,
  input logic                    reset_l,
  matrix_bus_sequencer_if.master bus
);
  localparam int N  = REGISTER_SIZE * REGISTER_SIZE;
  localparam int CW = $clog2(N);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FILL_A, WRITE_A, FILL_B, WRITE_B, READ, DRAIN} state_t;
  state_t                 state, state_nx;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          tmo;
  logic [MEMORY_SIZE-1:0] wdata, result;
  logic                   op, accept, xfer, last, expired;
  assign accept  = bus.in_valid && bus.in_ready;
  assign xfer    = bus.out_valid && bus.out_ready;
  assign last    = cnt == CW'(N - 1);
  assign expired = tmo == TW'(DONE_TIMEOUT - 1);
  assign bus.bus_wdata = wdata;
  assign bus.out_data  = result[MEMORY_SIZE-1 -: DATASIZE];
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) state <= IDLE;
    else          state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = FILL_A;
      FILL_A:  if (accept && last) state_nx = WRITE_A;
      WRITE_A: state_nx = FILL_B;
      FILL_B:  if (accept && last) state_nx = WRITE_B;
      WRITE_B: state_nx = READ;
      READ:    if (bus.done) state_nx = DRAIN;
               else if (expired) state_nx = IDLE;
      DRAIN:   if (xfer && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // in_ready is gated by reset_l so every output reads 0 while reset is held
  always_comb begin
    bus.in_ready  = reset_l && (state == IDLE || state == FILL_A || state == FILL_B);
    bus.enable    = state == WRITE_A || state == WRITE_B || state == READ;
    bus.select    = state == WRITE_A || state == WRITE_B || state == READ;
    bus.readwrite = state == WRITE_A || state == WRITE_B;
    bus.ab_select = state == WRITE_B;
    bus.addsub    = state == READ && op;
    bus.out_valid = state == DRAIN;
    bus.busy      = state != IDLE;
  end
  // Both matrices shift in at the LSB end so element 0 lands in the MSB slice;
  // the result shifts out from the MSB end, reusing the wrapped element counter.
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      cnt             <= '0;
      tmo             <= '0;
      wdata           <= '0;
      result          <= '0;
      op              <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      if (accept || xfer) cnt <= cnt + 1'b1;
      if (accept) wdata <= {wdata[MEMORY_SIZE-DATASIZE-1:0], bus.in_data};
      if (accept && state == IDLE) begin
        op              <= bus.op_addsub;
        bus.timeout_err <= 1'b0;
      end
      tmo <= (state == READ) ? tmo + 1'b1 : '0;
      if (state == READ && bus.done) result <= bus.bus_rdata;
      else if (xfer) result <= {result[MEMORY_SIZE-DATASIZE-1:0], {DATASIZE{1'b0}}};
      if (state == READ && !bus.done && expired) bus.timeout_err <= 1'b1;
    end
endmodule

// File: tb/tb_matrix_bus_sequencer.sv
// tb_matrix_bus_sequencer: randomized matrix transactions against an elementwise add/sub reference
module tb_matrix_bus_sequencer;
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;
  matrix_bus_sequencer_if #(.DATASIZE(16), .MEMORY_SIZE(256)) b ();
  matrix_bus_sequencer dut (.clk(clk), .reset_l(reset_l), .bus(b));
  int vectors = 0;
  int errors = 0;
  logic [15:0]  a_el [16];
  logic [15:0]  b_el [16];
  logic [15:0]  exp_q [16];
  logic [255:0] mem_a, mem_b;
  logic [15:0]  alu_x, alu_y;
  logic         seen_addsub;
  int wa_cnt = 0, wb_cnt = 0, rd_run = 0, rd_total = 0, alu_lat = 3;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // ALU stand-in: latches written matrices, answers a read after alu_lat cycles (0 = never)
  always @(negedge clk) begin
    if (!reset_l) begin
      rd_run = 0;
      b.done = 1'b0;
    end else begin
      b.done = 1'b0;
      if (b.enable && b.select && b.readwrite) begin
        if (b.ab_select) begin mem_b = b.bus_wdata; wb_cnt++; end
        else begin mem_a = b.bus_wdata; wa_cnt++; end
      end
      if (b.enable && b.select && !b.readwrite) begin
        rd_run++;
        rd_total++;
        if (rd_run == 1) seen_addsub = b.addsub;
        if (rd_run == alu_lat) begin
          for (int k = 0; k < 16; k++) begin
            alu_x = mem_a[255-16*k -: 16];
            alu_y = mem_b[255-16*k -: 16];
            b.bus_rdata[255-16*k -: 16] = b.addsub ? alu_x + alu_y : alu_x - alu_y;
          end
          b.done = 1'b1;
        end
      end else rd_run = 0;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 256'({b.in_ready, b.busy, b.enable, b.select, b.readwrite, b.ab_select,
                               b.addsub, b.out_valid, b.timeout_err}), 256'(0));
    check({tag, "_wdata"}, b.bus_wdata, 256'(0));
    check({tag, "_out_data"}, 256'(b.out_data), 256'(0));
  endtask

  task automatic send_stream(input logic op, input bit gappy);
    int i = 0;
    int t = 0;
    while (i < 32 && t < 400) begin
      @(negedge clk);
      t++;
      b.in_valid = !(gappy && (t % 2 == 1));
      if (i < 16) b.in_data = a_el[i];
      else b.in_data = b_el[i-16];
      b.op_addsub = (i == 0) ? op : ~op;
      if (b.in_valid && b.in_ready) i++;
    end
    @(negedge clk);
    b.in_valid = 1'b0;
    check("fill_count", 256'(i), 256'(32));
  endtask

  task automatic drain(input int stall_at);
    int k = 0;
    int t = 0;
    int s = stall_at;
    while (k < 16 && t < 600) begin
      @(negedge clk);
      t++;
      if (k == s && b.out_valid) begin
        b.out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("stall_valid", 256'(b.out_valid), 256'(1));
          check("stall_data", 256'(b.out_data), 256'(exp_q[k]));
        end
        s = -1;
      end
      b.out_ready = ($urandom_range(0, 3) != 0);
      if (b.out_valid && b.out_ready) begin
        check("out_data", 256'(b.out_data), 256'(exp_q[k]));
        k++;
      end
    end
    @(negedge clk);
    b.out_ready = 1'b0;
    check("drain_count", 256'(k), 256'(16));
  endtask

  task automatic run_txn(input logic op, input int lat, input bit gappy, input int stall_at);
    int wa0, wb0, r0, t;
    logic [255:0] pa, pb;
    wa0 = wa_cnt;
    wb0 = wb_cnt;
    r0 = rd_total;
    alu_lat = lat;
    for (int k = 0; k < 16; k++) begin
      pa[255-16*k -: 16] = a_el[k];
      pb[255-16*k -: 16] = b_el[k];
      exp_q[k] = op ? a_el[k] + b_el[k] : a_el[k] - b_el[k];
    end
    send_stream(op, gappy);
    if (lat == 0) begin
      t = 0;
      while (b.busy && t < 400) begin @(negedge clk); t++; end
      check("tmo_read_cycles", 256'(rd_total - r0), 256'(255));
      check("tmo_err", 256'(b.timeout_err), 256'(1));
      check("tmo_busy", 256'(b.busy), 256'(0));
      check("tmo_enable", 256'(b.enable), 256'(0));
    end else begin
      drain(stall_at);
      check("idle_busy", 256'(b.busy), 256'(0));
      check("err_clear", 256'(b.timeout_err), 256'(0));
      check("read_addsub", 256'(seen_addsub), 256'(op));
    end
    check("write_a_cycles", 256'(wa_cnt - wa0), 256'(1));
    check("write_b_cycles", 256'(wb_cnt - wb0), 256'(1));
    check("wdata_a", mem_a, pa);
    check("wdata_b", mem_b, pb);
  endtask

  task automatic rand_mats();
    for (int k = 0; k < 16; k++) begin
      a_el[k] = 16'($urandom);
      b_el[k] = 16'($urandom);
    end
  endtask

  initial begin
    b.in_valid = 1'b0;
    b.in_data = '0;
    b.op_addsub = 1'b0;
    b.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("por");
    reset_l = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 256'(b.in_ready), 256'(1));
    for (int k = 0; k < 16; k++) begin a_el[k] = 16'(k + 1); b_el[k] = 16'd1; end
    run_txn(1'b1, 3, 1'b0, -1);
    for (int k = 0; k < 16; k++) begin a_el[k] = 16'd5; b_el[k] = 16'd7; end
    run_txn(1'b0, 3, 1'b0, -1);
    rand_mats();
    run_txn(1'b1, 4, 1'b0, 5);
    rand_mats();
    run_txn(1'b0, 2, 1'b1, -1);
    rand_mats();
    run_txn(1'b1, 0, 1'b0, -1);
    rand_mats();
    run_txn(1'b0, 3, 1'b0, -1);
    rand_mats();
    for (int i = 0, t = 0; i < 9 && t < 50; t++) begin
      @(negedge clk);
      b.in_valid = 1'b1;
      b.in_data = a_el[i];
      if (b.in_ready) i++;
    end
    @(negedge clk);
    b.in_valid = 1'b0;
    #2 reset_l = 1'b0;
    #1 check_reset("mid_reset");
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", 256'(b.in_ready), 256'(1));
    run_txn(1'b1, 3, 1'b0, -1);
    for (int n = 0; n < 6; n++) begin
      rand_mats();
      run_txn(1'($urandom), int'($urandom_range(1, 6)), 1'($urandom),
              ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
